// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide sequencer beside the Ex stage.
// Accepts mult/multu/div/divu, holds the result for a fixed latency, then
// commits it to HI/LO. Also services mthi/mtlo and raises the decode stall.
// Optional macro MD_MADD_EN enables madd/maddu/msub (ops 4..6) that
// accumulate into {hi,lo}; without it those ops are ignored.
//
// Handshake: a request is taken on a rising edge when start & ~flush and the
// unit is IDLE with a legal op; busy is high for exactly the op latency, and
// HI/LO change on the edge that drops busy. stall_id is the only
// combinational output.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wd,
  input  logic        flush,
  input  logic        id_md_use,
  output logic        busy,
  output logic        stall_id,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [63:0] pend;
  logic        pend_keep;

  logic        legal;
  logic        is_div;
  logic        acc;
  logic [63:0] pend_nxt;
  logic        keep_nxt;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        b_safe;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  // A zero divisor is replaced by 1 so the dividers never produce X; the
  // result is discarded anyway through pend_keep.
  assign b_safe = (b == 32'd0) ? 32'd1 : b;
  assign sa     = a;
  assign sb     = b_safe;
  assign quot_s = sa / sb;
  assign rem_s  = sa % sb;
  assign quot_u = a / b_safe;
  assign rem_u  = a % b_safe;
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Stall decode while an md-class instruction waits behind a live op.
  assign stall_id = id_md_use & (busy | (start & ~flush));

  // Decode op legality and latency class, and qualify the request.
  always_comb begin
    is_div = (op == 3'd2) || (op == 3'd3);
`ifdef MD_MADD_EN
    legal  = (op != 3'd7);
`else
    legal  = (op <= 3'd3);
`endif
    acc    = start & ~flush & (state == IDLE) & legal;
  end

  // Result the unit will commit, computed from operands at the accept edge.
  always_comb begin
    pend_nxt = 64'd0;
    keep_nxt = 1'b0;
    case (op)
      3'd0: pend_nxt = prod_s;
      3'd1: pend_nxt = prod_u;
      3'd2: begin
        if (b == 32'd0)
          keep_nxt = 1'b1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          pend_nxt = {32'd0, 32'h8000_0000};
        else
          pend_nxt = {rem_s, quot_s};
      end
      3'd3: begin
        if (b == 32'd0)
          keep_nxt = 1'b1;
        else
          pend_nxt = {rem_u, quot_u};
      end
`ifdef MD_MADD_EN
      3'd4: pend_nxt = {hi, lo} + prod_s;
      3'd5: pend_nxt = {hi, lo} + prod_u;
      3'd6: pend_nxt = {hi, lo} - prod_s;
`endif
      default: ;
    endcase
  end

  // Sequencer: accept, count down the latency, commit, and handle mthi/mtlo.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cnt       <= 4'd0;
      pend      <= 64'd0;
      pend_keep <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            state     <= BUSY;
            busy      <= 1'b1;
            cnt       <= is_div ? DIV_N : MULT_N;
            pend      <= pend_nxt;
            pend_keep <= keep_nxt;
          end else if (~flush & ~start) begin
            if (hi_we) hi <= wd;
            if (lo_we) lo <= wd;
          end
        end
        BUSY: begin
          // flush here kills a younger instruction, not the op in flight.
          if (cnt == 4'd1) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 4'd0;
            if (!pend_keep) {hi, lo} <= pend;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed bench for md_ctrl. Stimulus pushes the hand-computed
// {hi,lo} and busy length of each op into queues; a monitor pops and checks
// them whenever busy falls. Build with MD_MADD_EN to cover ops 4..6.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, hi_we, lo_we, flush, id_md_use;
  logic [2:0]  op;
  logic [31:0] a, b, wd;
  logic        busy, stall_id;
  logic [31:0] hi, lo;

  logic [63:0] exp_q[$];
  int          len_q[$];
  logic [31:0] mdl_hi, mdl_lo;
  int          n_tests = 0;
  int          n_fail  = 0;

  md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wd(wd), .flush(flush),
    .id_md_use(id_md_use), .busy(busy), .stall_id(stall_id),
    .hi(hi), .lo(lo)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: measure each busy window and compare the committed HI/LO.
  initial begin
    logic        prev_busy;
    int          blen;
    logic [63:0] e;
    int          n;
    prev_busy = 1'b0;
    blen      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (prev_busy && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          n = len_q.pop_front();
        end
        prev_busy = 1'b0;
        blen      = 0;
      end else begin
        if (busy) begin
          blen++;
        end else if (prev_busy) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL commit_unexpected: got %h expected none", {hi, lo});
          end else begin
            e = exp_q.pop_front();
            n = len_q.pop_front();
            check("commit_hilo", {hi, lo}, e);
            check("busy_len", 64'(blen), 64'(n));
          end
          blen = 0;
        end
        prev_busy = busy;
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] e, input int n);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    exp_q.push_back(e);
    len_q.push_back(n);
    {mdl_hi, mdl_lo} = e;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 40);
    check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic mtx(input logic h, input logic l, input logic [31:0] d);
    @(posedge clk); #1;
    hi_we = h; lo_we = l; wd = d;
    if (h) mdl_hi = d;
    if (l) mdl_lo = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clk);
    check("mtx_hilo", {hi, lo}, {mdl_hi, mdl_lo});
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
    id_md_use = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; wd = 32'd0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    @(posedge clk); @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_stall", {63'd0, stall_id}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // mult -2*3 with decode holding an md-class op for 8 cycles
    @(posedge clk); #1;
    start = 1'b1; op = 3'd0; a = 32'hFFFF_FFFE; b = 32'd3; id_md_use = 1'b1;
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA); len_q.push_back(5);
    {mdl_hi, mdl_lo} = 64'hFFFF_FFFF_FFFF_FFFA;
    @(negedge clk);
    check("stall_start", {63'd0, stall_id}, 64'd1);
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      check("stall_busy", {63'd0, stall_id}, (i <= 5) ? 64'd1 : 64'd0);
    end
    @(posedge clk); #1 id_md_use = 1'b0;
    check("mflo_after_release", {32'd0, lo}, {32'd0, 32'hFFFF_FFFA});

    // divides
    issue(3'd3, 32'd7, 32'd2, {32'd1, 32'd3}, 10);                           wait_idle();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);   wait_idle();
    issue(3'd2, 32'd100, 32'hFFFF_FFF9, {32'd2, 32'hFFFF_FFF2}, 10);         wait_idle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10);   wait_idle();
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 5);   wait_idle();

    // start killed by flush: no busy, no stall, no HI/LO change
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5; id_md_use = 1'b1;
    @(negedge clk);
    check("flush_start_stall", {63'd0, stall_id}, 64'd0);
    @(posedge clk); #1 start = 1'b0; flush = 1'b0; id_md_use = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_start_busy", {63'd0, busy}, 64'd0);
    end
    check("flush_start_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    // flush mid-BUSY does not disturb the in-flight op
    issue(3'd0, 32'd6, 32'd7, {32'd0, 32'd42}, 5);
    @(posedge clk); @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    wait_idle();

    // mthi written during BUSY is ignored
    issue(3'd0, 32'd2, 32'd3, {32'd0, 32'd6}, 5);
    hi_we = 1'b1; wd = 32'hDEAD_BEEF;
    @(posedge clk); #1 hi_we = 1'b0;
    wait_idle();

    // mthi / mtlo / both
    mtx(1'b1, 1'b0, 32'h1234_5678);
    mtx(1'b0, 1'b1, 32'hCAFE_0001);
    mtx(1'b1, 1'b1, 32'h0BAD_F00D);
    mtx(1'b1, 1'b0, 32'h1234_5678);

    // divide by zero keeps HI/LO
    issue(3'd2, 32'd5, 32'd0, {mdl_hi, mdl_lo}, 10);   wait_idle();
    issue(3'd3, 32'd9, 32'd0, {mdl_hi, mdl_lo}, 10);   wait_idle();

    // op 7 is never legal
    @(posedge clk); #1 start = 1'b1; op = 3'd7; a = 32'd3; b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check("op7_busy", {63'd0, busy}, 64'd0);
    check("op7_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    // asynchronous reset on busy cycle 3
    issue(3'd0, 32'd6, 32'd7, {32'd0, 32'd42}, 5);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
    #1;
    check("rst_async_busy", {63'd0, busy}, 64'd0);
    check("rst_async_hilo", {hi, lo}, 64'd0);
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    check("rst_no_commit", {hi, lo}, 64'd0);

`ifdef MD_MADD_EN
    mtx(1'b0, 1'b1, 32'hFFFF_FFFF);
    issue(3'd4, 32'd1, 32'd1, {32'd1, 32'd0}, 5);                          wait_idle();
    issue(3'd6, 32'd1, 32'd1, {32'd0, 32'hFFFF_FFFF}, 5);                  wait_idle();
    issue(3'd5, 32'hFFFF_FFFF, 32'd2, 64'h0000_0002_FFFF_FFFD, 5);         wait_idle();
    issue(3'd6, 32'hFFFF_FFFF, 32'd1, 64'h0000_0002_FFFF_FFFE, 5);         wait_idle();
`else
    mtx(1'b0, 1'b1, 32'hFFFF_FFFF);
    for (int k = 4; k <= 6; k++) begin
      @(posedge clk); #1 start = 1'b1; op = 3'(k); a = 32'd1; b = 32'd1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      check("madd_off_busy", {63'd0, busy}, 64'd0);
      check("madd_off_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Multiply/divide sequencer sitting beside the Ex stage of the five-stage pipeline.
- Accepts mult/multu/div/divu requests and holds the result internally for a fixed latency.
- Commits the result to HI/LO when the latency expires, and writes HI/LO for mthi/mtlo.
- Drives a stall request back to the decode stage while any md-class instruction (mult/div/mfhi/mflo/mthi/mtlo) sits in decode and the unit is starting or busy.
- Qualifies requests with the pipeline flush so instructions killed by an exception never touch HI/LO.

Parameters:
- MULT_CYCLES, 5, busy cycles for multiply-class ops (valid range 2..15).
- DIV_CYCLES, 10, busy cycles for divide-class ops (valid range 2..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  Ex holds mult/multu/div/divu (or madd-class op when enabled).
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 msub, 7 reserved.
- a  input  32  rs operand (forwarded).
- b  input  32  rt operand (forwarded).
- hi_we  input  1  mthi in Ex.
- lo_we  input  1  mtlo in Ex.
- wd  input  32  mthi/mtlo data.
- flush  input  1  exception/eret taken this cycle; the Ex instruction is cancelled.
- id_md_use  input  1  decode holds an md-class instruction.
- busy  output  1  operation in flight.
- stall_id  output  1  stall request to the hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (async) values: busy=0, hi=0, lo=0, state=IDLE, cnt=0, pending result=0.
- stall_id = id_md_use & (busy | (start & ~flush)). This is the only combinational output.
- Accept condition: acc = start & ~flush & (state==IDLE) & legal op. Ops 4..6 are legal only with MD_MADD_EN; op 7 is never legal. Illegal ops are ignored and leave state unchanged.
- FSM states:
  - IDLE -> BUSY on acc. On this edge:
    - cnt loads MULT_CYCLES (ops 0,1,4,5,6) or DIV_CYCLES (ops 2,3).
    - Pending {hi,lo} is computed from a, b and the current hi/lo.
    - busy=1 from the next cycle.
  - BUSY: cnt decrements each cycle. On the edge where cnt==1: hi/lo take the pending value, busy=0, state returns to IDLE. Total visible busy is exactly N cycles; hi/lo update on the Nth edge after the accept edge.
- Arithmetic:
  - mult: signed 32x32 -> 64, hi = upper, lo = lower.
  - multu: unsigned 32x32 -> 64.
  - div: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned.
  - Divide by zero: accepted and busy for DIV_CYCLES; hi/lo keep their prior values at commit.
  - div 0x80000000 / -1: lo=0x80000000, hi=0.
- mthi/mtlo: when state==IDLE and ~flush, hi_we writes hi=wd and lo_we writes lo=wd on the next edge. If both are set, both are written. Writes arriving during BUSY are ignored (decode stalling makes this unreachable; the bench flags it).
- Simultaneous start and hi_we/lo_we in IDLE cannot occur (single Ex instruction); start wins if forced.
- flush while BUSY: the in-flight op belongs to an older, committed instruction, so the unit continues and commits normally.
- flush on the same cycle as start/hi_we/lo_we: that request is dropped. No busy, no HI/LO change.
- start while BUSY: unreachable because of stall_id; ignored.
- reset mid-operation: immediate return to reset values; the pending result is discarded.

Optional Feature:
- Macro: MD_MADD_EN.
- Defined: ops 4/5/6 are legal with MULT_CYCLES latency, computed with modulo-2^64 wrap:
  - madd: {hi,lo} += signed a*b.
  - maddu: {hi,lo} += unsigned a*b.
  - msub: {hi,lo} -= signed a*b.
  - The accumulate uses hi/lo as sampled at the accept edge.
- Undefined: ops 4..6 are treated as illegal and ignored, with no busy and no HI/LO change. No accumulate hardware is built.

Test Plan:
- mult a=0xFFFFFFFE (-2), b=3 -> busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; busy=0 on cycle 6.
- divu a=7, b=2 -> busy for 10 cycles; then hi=1, lo=3. div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- start=1 with flush=1 -> busy stays 0 and hi/lo unchanged. Separately, flush pulsed mid-BUSY -> result still commits on schedule.
- mult accepted, then id_md_use=1 for 8 cycles -> stall_id=1 on the start cycle and on busy cycles 1..5, 0 afterwards. mflo after release reads the new lo.
- mthi wd=0x12345678 in IDLE -> hi=0x12345678. div by zero afterwards -> hi/lo unchanged after 10 cycles.
- reset asserted on BUSY cycle 3 -> busy=0, hi=lo=0 asynchronously. With MD_MADD_EN: hi=0, lo=0xFFFFFFFF, madd 1*1 -> hi=1, lo=0.
